// File: rtl/taxi_axil_reg_pkg.sv
// Shared types for the AXI4-Lite register bank: response codes and the
// write/read channel state encodings.
package taxi_axil_reg_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } r_state_t;

endpackage

// File: rtl/taxi_axil_reg_bank_wr_ch.sv
// AXI4-Lite write channel: independent AW/W capture, join, decode and B response.
// Emits a combinational commit strobe in the join cycle for OKAY writes.
module taxi_axil_reg_bank_wr_ch
    import taxi_axil_reg_pkg::*;
#(
    parameter int REG_COUNT = 16,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 8,
    parameter int STRB_W    = DATA_W / 8,
    parameter logic [REG_COUNT-1:0] RO_MASK = '0,
    parameter int REG_IDX_W = $clog2(REG_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    awaddr_i,
    input  logic                 awvalid_i,
    output logic                 awready_o,
    input  logic [DATA_W-1:0]    wdata_i,
    input  logic [STRB_W-1:0]    wstrb_i,
    input  logic                 wvalid_i,
    output logic                 wready_o,
    output logic [1:0]           bresp_o,
    output logic                 bvalid_o,
    input  logic                 bready_i,
    output logic                 commit_o,
    output logic [REG_IDX_W-1:0] idx_o,
    output logic [DATA_W-1:0]    data_o,
    output logic [STRB_W-1:0]    strb_o
);

    localparam int LSB   = $clog2(STRB_W);
    localparam int IDX_W = ADDR_W - LSB;

    w_state_t          state_q, state_d;
    logic              aw_held_q, aw_held_d;
    logic              w_held_q, w_held_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    resp_t             bresp_q, bresp_d;
    logic              aw_fire_s, w_fire_s, join_s;
    logic [IDX_W-1:0]  idx_s;
    resp_t             resp_s;
    logic              unused_addr_s;

    assign unused_addr_s = ^awaddr_d[LSB-1:0];

    // Next-state: capture/join of AW and W, decode, and B handshake
    always_comb begin
        aw_fire_s = awvalid_i && awready_q;
        w_fire_s  = wvalid_i && wready_q;
        awaddr_d  = aw_fire_s ? awaddr_i : awaddr_q;
        wdata_d   = w_fire_s ? wdata_i : wdata_q;
        wstrb_d   = w_fire_s ? wstrb_i : wstrb_q;
        aw_held_d = aw_held_q || aw_fire_s;
        w_held_d  = w_held_q || w_fire_s;
        state_d   = state_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        join_s    = 1'b0;

        idx_s = awaddr_d[ADDR_W-1:LSB];
        if (32'(idx_s) >= 32'(REG_COUNT)) begin
            resp_s = DECERR;
        end else if (RO_MASK[idx_s[REG_IDX_W-1:0]]) begin
            resp_s = SLVERR;
        end else begin
            resp_s = OKAY;
        end

        case (state_q)
            W_IDLE: begin
                if (aw_held_d && w_held_d) begin
                    join_s   = 1'b1;
                    state_d  = W_RESP;
                    bvalid_d = 1'b1;
                    bresp_d  = resp_s;
                end else begin
                    state_d = W_IDLE;
                end
            end
            W_RESP: begin
                if (bready_i) begin
                    state_d   = W_IDLE;
                    bvalid_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                end else begin
                    state_d = W_RESP;
                end
            end
            default: begin
                state_d   = W_IDLE;
                bvalid_d  = 1'b0;
                aw_held_d = 1'b0;
                w_held_d  = 1'b0;
            end
        endcase

        awready_d = (state_d == W_IDLE) && !aw_held_d;
        wready_d  = (state_d == W_IDLE) && !w_held_d;
        commit_o  = join_s && (resp_s == OKAY);
        idx_o     = idx_s[REG_IDX_W-1:0];
        data_o    = wdata_d;
        strb_o    = wstrb_d;
    end

    // State and handshake registers; readies stay low until the first edge out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
        end else begin
            state_q   <= state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    assign awready_o = awready_q;
    assign wready_o  = wready_q;
    assign bvalid_o  = bvalid_q;
    assign bresp_o   = bresp_q;

endmodule

// File: rtl/taxi_axil_reg_bank.sv
// AXI4-Lite slave register bank: writable control registers, read-only status
// registers, and per-register write/read strobes for fabric side effects.
module taxi_axil_reg_bank
    import taxi_axil_reg_pkg::*;
#(
    parameter int REG_COUNT = 16,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 8,
    parameter int STRB_W    = DATA_W / 8,
    parameter logic [REG_COUNT-1:0]        RO_MASK   = '0,
    parameter logic [REG_COUNT*DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDR_W-1:0]           s_axil_awaddr_i,
    input  logic                        s_axil_awvalid_i,
    output logic                        s_axil_awready_o,
    input  logic [DATA_W-1:0]           s_axil_wdata_i,
    input  logic [STRB_W-1:0]           s_axil_wstrb_i,
    input  logic                        s_axil_wvalid_i,
    output logic                        s_axil_wready_o,
    output logic [1:0]                  s_axil_bresp_o,
    output logic                        s_axil_bvalid_o,
    input  logic                        s_axil_bready_i,
    input  logic [ADDR_W-1:0]           s_axil_araddr_i,
    input  logic                        s_axil_arvalid_i,
    output logic                        s_axil_arready_o,
    output logic [DATA_W-1:0]           s_axil_rdata_o,
    output logic [1:0]                  s_axil_rresp_o,
    output logic                        s_axil_rvalid_o,
    input  logic                        s_axil_rready_i,
    output logic [REG_COUNT*DATA_W-1:0] reg_out,
    input  logic [REG_COUNT*DATA_W-1:0] reg_in,
    output logic [REG_COUNT-1:0]        wr_pulse,
    output logic [REG_COUNT-1:0]        rd_pulse
);

    localparam int LSB       = $clog2(STRB_W);
    localparam int IDX_W     = ADDR_W - LSB;
    localparam int REG_IDX_W = $clog2(REG_COUNT);

    function automatic logic [DATA_W-1:0] merge_strb(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] res;
        res = old_v;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_v[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_v[b*8 +: 8];
            end
        end
        return res;
    endfunction

    logic                 wr_commit_s;
    logic [REG_IDX_W-1:0] wr_idx_s;
    logic [DATA_W-1:0]    wr_data_s;
    logic [STRB_W-1:0]    wr_strb_s;

    logic [DATA_W-1:0]    reg_q [REG_COUNT];
    logic [REG_COUNT-1:0] wr_pulse_q;

    taxi_axil_reg_bank_wr_ch #(
        .REG_COUNT (REG_COUNT),
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .STRB_W    (STRB_W),
        .RO_MASK   (RO_MASK),
        .REG_IDX_W (REG_IDX_W)
    ) u_wr_ch (
        .clk       (clk),
        .rst       (rst),
        .awaddr_i  (s_axil_awaddr_i),
        .awvalid_i (s_axil_awvalid_i),
        .awready_o (s_axil_awready_o),
        .wdata_i   (s_axil_wdata_i),
        .wstrb_i   (s_axil_wstrb_i),
        .wvalid_i  (s_axil_wvalid_i),
        .wready_o  (s_axil_wready_o),
        .bresp_o   (s_axil_bresp_o),
        .bvalid_o  (s_axil_bvalid_o),
        .bready_i  (s_axil_bready_i),
        .commit_o  (wr_commit_s),
        .idx_o     (wr_idx_s),
        .data_o    (wr_data_s),
        .strb_o    (wr_strb_s)
    );

    // Register storage and write strobe, updated on the edge after the AW/W join
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                reg_q[i] <= RESET_VAL[i*DATA_W +: DATA_W];
            end
            wr_pulse_q <= '0;
        end else begin
            wr_pulse_q <= '0;
            if (wr_commit_s) begin
                reg_q[wr_idx_s]      <= merge_strb(reg_q[wr_idx_s], wr_data_s, wr_strb_s);
                wr_pulse_q[wr_idx_s] <= 1'b1;
            end else begin
                wr_pulse_q <= '0;
            end
        end
    end

    for (genvar g = 0; g < REG_COUNT; g++) begin : g_reg_out
        assign reg_out[g*DATA_W +: DATA_W] = reg_q[g];
    end

    assign wr_pulse = wr_pulse_q;

    r_state_t             r_state_q, r_state_d;
    logic                 arready_q, arready_d;
    logic                 rvalid_q, rvalid_d;
    resp_t                rresp_q, rresp_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic [REG_COUNT-1:0] rd_pulse_q, rd_pulse_d;
    logic                 ar_fire_s;
    logic [IDX_W-1:0]     ridx_s;
    logic [REG_IDX_W-1:0] rsel_s;
    logic                 unused_araddr_s;

    assign unused_araddr_s = ^s_axil_araddr_i[LSB-1:0];

    // Read next-state: pre-write register value or live status input, decoded on AR accept
    always_comb begin
        ar_fire_s  = s_axil_arvalid_i && arready_q;
        ridx_s     = s_axil_araddr_i[ADDR_W-1:LSB];
        rsel_s     = ridx_s[REG_IDX_W-1:0];
        r_state_d  = r_state_q;
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        rd_pulse_d = '0;

        case (r_state_q)
            R_IDLE: begin
                if (ar_fire_s) begin
                    r_state_d = R_RESP;
                    rvalid_d  = 1'b1;
                    if (32'(ridx_s) >= 32'(REG_COUNT)) begin
                        rresp_d = DECERR;
                        rdata_d = '0;
                    end else begin
                        rresp_d            = OKAY;
                        rd_pulse_d[rsel_s] = 1'b1;
                        if (RO_MASK[rsel_s]) begin
                            rdata_d = reg_in[32'(rsel_s)*DATA_W +: DATA_W];
                        end else begin
                            rdata_d = reg_q[rsel_s];
                        end
                    end
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_RESP: begin
                if (s_axil_rready_i) begin
                    r_state_d = R_IDLE;
                    rvalid_d  = 1'b0;
                end else begin
                    r_state_d = R_RESP;
                end
            end
            default: begin
                r_state_d = R_IDLE;
                rvalid_d  = 1'b0;
            end
        endcase

        arready_d = (r_state_d == R_IDLE);
    end

    // Read channel registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q  <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= OKAY;
            rdata_q    <= '0;
            rd_pulse_q <= '0;
        end else begin
            r_state_q  <= r_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            rd_pulse_q <= rd_pulse_d;
        end
    end

    assign s_axil_arready_o = arready_q;
    assign s_axil_rvalid_o  = rvalid_q;
    assign s_axil_rresp_o   = rresp_q;
    assign s_axil_rdata_o   = rdata_q;
    assign rd_pulse         = rd_pulse_q;

endmodule

// File: tb/tb_taxi_axil_reg_bank.sv
// Self-checking bench: directed scenarios plus randomized AXI4-Lite traffic
// compared against an array-based model of the register map.
module tb_taxi_axil_reg_bank;

    localparam int REG_COUNT = 16;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 8;
    localparam int STRB_W    = 4;
    localparam logic [15:0] RO_MASK = 16'h0108;

    function automatic logic [511:0] mk_reset_val();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = 32'hA500_0000 | 32'(i);
        return v;
    endfunction
    localparam logic [511:0] RESET_VAL = mk_reset_val();

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   awaddr = 8'h00, araddr = 8'h00;
    logic         awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0]  wdata = 32'h0;
    logic [3:0]   wstrb = 4'h0;
    logic         awready, wready, bvalid, arready, rvalid;
    logic [1:0]   bresp, rresp;
    logic [31:0]  rdata;
    logic [511:0] reg_out, reg_in;
    logic [15:0]  wr_pulse, rd_pulse;

    taxi_axil_reg_bank #(
        .REG_COUNT (REG_COUNT),
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .STRB_W    (STRB_W),
        .RO_MASK   (RO_MASK),
        .RESET_VAL (RESET_VAL)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .s_axil_awaddr_i  (awaddr),
        .s_axil_awvalid_i (awvalid),
        .s_axil_awready_o (awready),
        .s_axil_wdata_i   (wdata),
        .s_axil_wstrb_i   (wstrb),
        .s_axil_wvalid_i  (wvalid),
        .s_axil_wready_o  (wready),
        .s_axil_bresp_o   (bresp),
        .s_axil_bvalid_o  (bvalid),
        .s_axil_bready_i  (bready),
        .s_axil_araddr_i  (araddr),
        .s_axil_arvalid_i (arvalid),
        .s_axil_arready_o (arready),
        .s_axil_rdata_o   (rdata),
        .s_axil_rresp_o   (rresp),
        .s_axil_rvalid_o  (rvalid),
        .s_axil_rready_i  (rready),
        .reg_out          (reg_out),
        .reg_in           (reg_in),
        .wr_pulse         (wr_pulse),
        .rd_pulse         (rd_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: one word per register index, plain arithmetic decode.
    logic [31:0] m_reg [16];
    logic [31:0] rd_exp_data;
    logic [1:0]  rd_exp_resp;

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = RESET_VAL[i*32 +: 32];
    endtask

    function automatic logic [511:0] m_vec();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = m_reg[i];
        return v;
    endfunction

    function automatic logic [1:0] m_wr_resp(input logic [7:0] addr);
        int idx;
        idx = int'(addr) / 4;
        if (idx >= REG_COUNT) return 2'b11;
        if (RO_MASK[idx]) return 2'b10;
        return 2'b00;
    endfunction

    task automatic m_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] mask;
        int idx;
        idx = int'(addr) / 4;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        m_reg[idx] = (m_reg[idx] & ~mask) | (data & mask);
    endtask

    function automatic logic [15:0] onehot(input logic [7:0] addr);
        logic [15:0] v;
        v = 16'h0001;
        return v << (int'(addr) / 4);
    endfunction

    task automatic axil_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                              input int aw_lag, input int w_lag, input int b_delay, input bit leave_b);
        bit aw_done, w_done, aw_hs, w_hs;
        int cyc;
        logic [1:0] exp_resp;
        aw_done = 1'b0; w_done = 1'b0; cyc = 0;
        exp_resp = m_wr_resp(addr);
        awaddr = addr; wdata = data; wstrb = strb;
        while (!(aw_done && w_done) && cyc < 100) begin
            if (w_done && !aw_done) check("wr_w_held_readies", {awready, wready}, 2'b10);
            if (aw_done && !w_done) check("wr_aw_held_readies", {awready, wready}, 2'b01);
            awvalid = !aw_done && (cyc >= aw_lag);
            wvalid  = !w_done && (cyc >= w_lag);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_hs) aw_done = 1'b1;
            if (w_hs) w_done = 1'b1;
            cyc++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (!(aw_done && w_done)) begin
            check("wr_handshake_timeout", 1'b0, 1'b1);
            return;
        end
        if (exp_resp == 2'b00) m_write(addr, data, strb);
        check("wr_bvalid", bvalid, 1'b1);
        check("wr_bresp", bresp, exp_resp);
        check("wr_pulse", wr_pulse, (exp_resp == 2'b00) ? onehot(addr) : 16'h0000);
        check("wr_reg_out", reg_out, m_vec());
        check("wr_readies_in_resp", {awready, wready}, 2'b00);
        if (leave_b) return;
        for (int d = 0; d < b_delay; d++) begin
            @(posedge clk); #1;
            check("wr_pulse_one_cycle", wr_pulse, 16'h0000);
            check("wr_b_hold", {bvalid, bresp}, {1'b1, exp_resp});
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check("wr_b_done", bvalid, 1'b0);
        check("wr_pulse_after_b", wr_pulse, 16'h0000);
        check("wr_readies_back", {awready, wready}, 2'b11);
    endtask

    task automatic axil_read_start(input logic [7:0] addr, input int ar_lag);
        int idx, cyc;
        bit done, hs;
        idx = int'(addr) / 4;
        if (idx >= REG_COUNT) begin
            rd_exp_resp = 2'b11; rd_exp_data = 32'h0;
        end else begin
            rd_exp_resp = 2'b00;
            rd_exp_data = RO_MASK[idx] ? reg_in[idx*32 +: 32] : m_reg[idx];
        end
        araddr = addr; done = 1'b0; cyc = 0;
        while (!done && cyc < 100) begin
            arvalid = (cyc >= ar_lag);
            hs = arvalid && arready;
            @(posedge clk); #1;
            if (hs) done = 1'b1;
            cyc++;
        end
        arvalid = 1'b0;
        if (!done) begin
            check("rd_handshake_timeout", 1'b0, 1'b1);
            return;
        end
        check("rd_rvalid", rvalid, 1'b1);
        check("rd_rresp", rresp, rd_exp_resp);
        check("rd_rdata", rdata, rd_exp_data);
        check("rd_pulse", rd_pulse, (rd_exp_resp == 2'b00) ? onehot(addr) : 16'h0000);
        check("rd_arready_busy", arready, 1'b0);
    endtask

    task automatic axil_read_end(input int r_delay);
        for (int d = 0; d < r_delay; d++) begin
            @(posedge clk); #1;
            check("rd_pulse_one_cycle", rd_pulse, 16'h0000);
            check("rd_hold", {rvalid, rresp, rdata}, {1'b1, rd_exp_resp, rd_exp_data});
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        check("rd_done", rvalid, 1'b0);
        check("rd_arready_back", arready, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) reg_in[i*32 +: 32] = $urandom;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_readies", {awready, wready, arready}, 3'b000);
        check("rst_valids", {bvalid, rvalid}, 2'b00);
        check("rst_resp_data", {bresp, rresp, rdata}, 36'h0);
        check("rst_reg_out", reg_out, RESET_VAL);
        check("rst_pulses", {wr_pulse, rd_pulse}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_release_readies_low", {awready, wready, arready}, 3'b000);
        @(posedge clk); #1;
        check("rst_release_readies", {awready, wready, arready}, 3'b111);

        // Same-cycle AW/W
        axil_write(8'h08, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 1'b0);
        check("t1_reg2", reg_out[95:64], 32'hDEAD_BEEF);

        // W three cycles ahead of AW, partial strobe over a zeroed register
        axil_write(8'h04, 32'h0000_0000, 4'hF, 0, 0, 1, 1'b0);
        axil_write(8'h04, 32'h1122_3344, 4'b0101, 3, 0, 2, 1'b0);
        check("t2_reg1", reg_out[63:32], 32'h0022_0044);

        // Read-only register
        reg_in[3*32 +: 32] = 32'hCAFE_0001;
        axil_read_start(8'h0C, 0);
        check("t3_ro_rdata", rdata, 32'hCAFE_0001);
        axil_read_end(1);
        axil_write(8'h0C, 32'h1234_5678, 4'hF, 0, 1, 0, 1'b0);

        // Out-of-range decode
        axil_read_start(8'h40, 1);
        axil_read_end(0);
        axil_write(8'h44, 32'hFFFF_FFFF, 4'hF, 1, 0, 0, 1'b0);

        // Zero strobe still pulses and leaves data untouched
        axil_write(8'h18, 32'h5555_AAAA, 4'h0, 0, 0, 0, 1'b0);

        // Stalled R channel while writes complete
        axil_read_start(8'h14, 0);
        axil_write(8'h14, 32'h0BAD_F00D, 4'hF, 0, 0, 0, 1'b0);
        axil_write(8'h1C, 32'h7777_8888, 4'h3, 1, 0, 1, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        check("t5_r_stalled", {rvalid, arready, rdata}, {1'b1, 1'b0, rd_exp_data});
        axil_read_end(0);

        // Read and write to the same index in the same cycle
        fork
            axil_read_start(8'h08, 0);
            axil_write(8'h08, 32'h1234_5678, 4'hF, 0, 0, 0, 1'b0);
        join
        check("t6_prewrite", rdata, 32'hDEAD_BEEF);
        axil_read_end(1);

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            logic [7:0] a;
            a = 8'(($urandom_range(0, 19)) * 4) | 8'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) begin
                axil_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                           $urandom_range(0, 3), 1'b0);
            end else begin
                for (int i = 0; i < 16; i++) reg_in[i*32 +: 32] = $urandom;
                axil_read_start(a, $urandom_range(0, 2));
                axil_read_end($urandom_range(0, 3));
            end
        end

        // Asynchronous reset while a B response is pending
        axil_write(8'h10, 32'h600D_CAFE, 4'hF, 0, 0, 0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("t7_bvalid_drop", bvalid, 1'b0);
        check("t7_reg_out_reset", reg_out, RESET_VAL);
        check("t7_readies_low", {awready, wready, arready}, 3'b000);
        m_reset();
        bready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("t7_no_b_after_reset", bvalid, 1'b0);
        end
        bready = 1'b0;
        axil_write(8'h10, 32'h0102_0304, 4'hF, 0, 0, 0, 1'b0);
        axil_read_start(8'h10, 0);
        axil_read_end(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/taxi_axil_reg_bank.md
Name: taxi_axil_reg_bank

Overview:
- AXI4-Lite slave register bank that sits directly downstream of the I2C-to-AXI-Lite bridge master.
- Gives an external I2C host a block of REG_COUNT control/status registers.
- Writable registers drive fabric control outputs; read-only registers reflect fabric status inputs.
- Per-register write/read strobe pulses let the fabric implement clear-on-read and write-triggered actions.

Parameters:
- REG_COUNT, 16, number of DATA_W-wide registers; power of two, 2..256.
- RO_MASK, '0, REG_COUNT-bit mask; bit i=1 makes register i read-only (reads reg_in slice i, writes rejected).
- RESET_VAL, '0, REG_COUNT*DATA_W flattened reset values for writable registers.
- DATA_W, ADDR_W and STRB_W are taken from the s_axil_wr interface; DATA_W is 32 or 64.

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- s_axil_wr  taxi_axil_if.wr_slv  -  AXI4-Lite write slave
- s_axil_rd  taxi_axil_if.rd_slv  -  AXI4-Lite read slave
- reg_out  output  REG_COUNT*DATA_W  current writable register contents; slice i is register i
- reg_in  input  REG_COUNT*DATA_W  status values for RO registers; slices for writable registers are ignored
- wr_pulse  output  REG_COUNT  one-cycle strobe per register on an accepted OKAY write
- rd_pulse  output  REG_COUNT  one-cycle strobe per register on an accepted OKAY read

Behaviour:
- Reset (asynchronous, active-high):
  - awready, wready, bvalid, arready, rvalid all 0; bresp/rresp 2'b00; rdata 0.
  - reg_out = RESET_VAL; wr_pulse and rd_pulse 0.
  - awready, wready and arready rise on the first clk edge after rst deasserts.
- Decode:
  - idx = addr[ADDR_W-1:$clog2(STRB_W)].
  - idx >= REG_COUNT → DECERR (2'b11).
  - Write to a RO_MASK register → SLVERR (2'b10).
  - Reads of any in-range register → OKAY.
  - awprot/arprot and user fields are ignored.
- Write channel, states W_IDLE, W_RESP:
  - AW and W are accepted independently. awready=1 while no address is held; wready=1 while no data is held.
  - Either one may arrive first, in any order or in the same cycle; the other is held until its partner arrives.
  - Cycle C = the cycle in which both are held:
    - At edge C+1, bytes with wstrb=1 update reg_out[idx] (OKAY writes only).
    - At the same edge: wr_pulse[idx]=1 for exactly one cycle, bvalid=1 with bresp, state → W_RESP.
  - While in W_RESP, awready=wready=0; hold bvalid/bresp until bready.
  - On the bvalid&&bready cycle, clear the held flags and return to W_IDLE; both readies reassert the next cycle.
  - One write outstanding at most.
  - wstrb=0 is OKAY, changes no data, and still pulses wr_pulse.
  - Rejected writes (SLVERR/DECERR) change no state and do not pulse.
- Read channel, states R_IDLE, R_RESP:
  - arready=1 in R_IDLE.
  - On arvalid&&arready at cycle C, at edge C+1:
    - rdata = reg_out[idx] for writable, or reg_in[idx] sampled in cycle C for RO; 0 on DECERR.
    - rvalid=1, rresp set, rd_pulse[idx]=1 for one cycle (OKAY only).
  - Hold rdata/rvalid/rresp until rready; then return to R_IDLE, with arready reasserting the next cycle.
  - One read outstanding at most.
- Simultaneous events:
  - Read and write channels are fully independent.
  - A read sampled in the same cycle C as a write to the same index returns the pre-write value.
- Backpressure: bready or rready held low indefinitely stalls only that channel; the other channel keeps operating.
- Reset mid-transaction: any held AW/W/AR and pending B/R are dropped with no response; registers return to RESET_VAL.

Decomposition:
- Package taxi_axil_reg_pkg:
  - resp_t enum {OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11}.
  - w_state_t and r_state_t enums.
- Optional sub-module taxi_axil_reg_bank_wr_ch: AW/W capture/join plus B response FSM, outputting a write-commit strobe, idx and strobed data.
- The read path and register storage stay in the top module.

Test Plan:
- Reset, then write 0xDEADBEEF to reg 2 (addr 0x08, DATA_W=32), AW and W in the same cycle → reg_out[2]=0xDEADBEEF one cycle after the handshake, wr_pulse[2] high for one cycle, bresp=OKAY.
- Send W (data 0x11223344, wstrb 4'b0101) three cycles before AW addr 0x04, with reg 1 previously 0 → reg_out[1]=0x00220044, awready stays low only after both are held, one B response.
- RO_MASK[3]=1, reg_in[3]=0xCAFE0001: read addr 0x0C → rdata 0xCAFE0001, OKAY, rd_pulse[3]=1; write addr 0x0C → bresp SLVERR, no wr_pulse.
- REG_COUNT=16: read addr 0x40 → rresp DECERR, rdata 0; write addr 0x44 → DECERR, reg_out unchanged.
- Hold rready=0 for 20 cycles after a read while performing two back-to-back writes → writes complete normally; R stays stable; arready=0 until rready.
- Assert rst asynchronously (mid-cycle) while bvalid=1 → bvalid falls immediately, reg_out returns to RESET_VAL, no B is issued after release.
